img_window_seq: RTL

IMG_WINDOW_SEQ -- requirements
Module: img_window_seq

---
 rtl/img_window_seq.sv | 112 +++++++++++
 1 files changed

// File: rtl/img_window_seq.sv
// img_window_seq: loads a 24-bit pixel stream into a byte buffer, then streams every 7-byte sliding window.
// Ports:
//   clk, rstn                      clock, asynchronous active-low reset
//   start, num_beats               job request and beat count (latched on accepted start)
//   s_axis_tdata/tvalid/tlast/tready  input pixel stream, 3 bytes per beat
//   buf_ce, buf_we, buf_addr, buf_d   image buffer control, byte address and write data
//   buf_q                          combinational 7-byte read window from the buffer
//   m_axis_tdata/tvalid/tlast/tready  window output stream
//   busy, done, err                job status
module img_window_seq #(
    parameter int ADDR_W = 18,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              start,
    input  logic [CNT_W-1:0]  num_beats,
    input  logic [23:0]       s_axis_tdata,
    input  logic              s_axis_tvalid,
    input  logic              s_axis_tlast,
    output logic              s_axis_tready,
    output logic              buf_ce,
    output logic              buf_we,
    output logic [ADDR_W-1:0] buf_addr,
    output logic [23:0]       buf_d,
    input  logic [55:0]       buf_q,
    output logic [55:0]       m_axis_tdata,
    output logic              m_axis_tvalid,
    output logic              m_axis_tlast,
    input  logic              m_axis_tready,
    output logic              busy,
    output logic              done,
    output logic              err
);
    // Wide enough for both the buffer address and 3*num_beats without truncation.
    localparam int W = (ADDR_W > CNT_W + 2) ? ADDR_W : CNT_W + 2;

    typedef enum logic [1:0] {IDLE, LOAD, READ, DONE} state_t;

    state_t            state;
    logic [CNT_W-1:0]  nb;
    logic [CNT_W-1:0]  beat_cnt;
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [W-1:0]      nwin;
    logic              last_beat;
    logic              more;
    logic              ld;

    assign nwin      = W'(nb) * W'(3) - W'(6);
    assign last_beat = beat_cnt == nb - CNT_W'(1);
    assign more      = W'(rd_ptr) < nwin;
    // Output register refills whenever it is empty or being drained this cycle.
    assign ld        = state == READ && more && (!m_axis_tvalid || m_axis_tready);

    assign s_axis_tready = state == LOAD;
    assign buf_we        = state == LOAD && s_axis_tvalid;
    assign buf_ce        = buf_we || state == READ;
    assign buf_addr      = state == LOAD ? wr_ptr : state == READ ? rd_ptr : '0;
    assign buf_d         = state == LOAD ? s_axis_tdata : '0;
    assign busy          = state != IDLE;
    assign done          = state == DONE;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state         <= IDLE;
            nb            <= '0;
            beat_cnt      <= '0;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            err           <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tvalid <= 1'b0;
            m_axis_tlast  <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    nb       <= num_beats;
                    beat_cnt <= '0;
                    wr_ptr   <= '0;
                    rd_ptr   <= '0;
                    // Fewer than 3 beats cannot form a single 7-byte window.
                    err      <= num_beats < CNT_W'(3);
                    state    <= num_beats < CNT_W'(3) ? DONE : LOAD;
                end
                LOAD: if (s_axis_tvalid) begin
                    wr_ptr   <= wr_ptr + ADDR_W'(3);
                    beat_cnt <= beat_cnt + CNT_W'(1);
                    if (last_beat) begin
                        state <= READ;
                        if (!s_axis_tlast) err <= 1'b1;
                    end else if (s_axis_tlast) begin
                        err <= 1'b1;
                    end
                end
                READ: begin
                    if (ld) begin
                        m_axis_tdata  <= buf_q;
                        m_axis_tvalid <= 1'b1;
                        m_axis_tlast  <= W'(rd_ptr) == nwin - W'(1);
                        rd_ptr        <= rd_ptr + ADDR_W'(1);
                    end else if (m_axis_tready) begin
                        m_axis_tvalid <= 1'b0;
                        m_axis_tlast  <= 1'b0;
                    end
                    if (m_axis_tvalid && m_axis_tready && m_axis_tlast) state <= DONE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
